// File: rtl/dat_rx_phys_if.sv
// SD data-line receive bus: card DAT lines, transfer control,
// Rx FIFO write port and transfer status flags.
interface dat_rx_phys_if #(
    parameter int FIFO_WIDTH      = 32,
    parameter int BLOCK_SZ_WIDTH  = 12,
    parameter int BLOCK_CNT_WIDTH = 16
);
    logic [3:0]                 DAT_din;
    logic [BLOCK_SZ_WIDTH-1:0]  block_sz;
    logic [BLOCK_CNT_WIDTH-1:0] block_cnt;
    logic                       read_flag;
    logic                       rx_buf_full;
    logic                       rx_buf_wr_enb;
    logic [FIFO_WIDTH-1:0]      rx_buf_din_out;
    logic                       rx_busy;
    logic                       tf_finished;
    logic                       crc_err;
    logic                       end_bit_err;
    logic                       timeout_err;
    logic                       overrun_err;

    modport slave (
        input  DAT_din, block_sz, block_cnt,
        input  read_flag, rx_buf_full,
        output rx_buf_wr_enb, rx_buf_din_out,
        output rx_busy, tf_finished,
        output crc_err, end_bit_err,
        output timeout_err, overrun_err
    );

    modport master (
        output DAT_din, block_sz, block_cnt,
        output read_flag, rx_buf_full,
        input  rx_buf_wr_enb, rx_buf_din_out,
        input  rx_busy, tf_finished,
        input  crc_err, end_bit_err,
        input  timeout_err, overrun_err
    );
endinterface

// File: rtl/dat_rx_phys.sv
// SD 4-bit DAT receive PHY: start-bit search, nibble assembly
// into FIFO words, per-line CRC16 check and end-bit check.
module dat_rx_phys #(
    parameter int FIFO_WIDTH      = 32,
    parameter int BLOCK_SZ_WIDTH  = 12,
    parameter int BLOCK_CNT_WIDTH = 16,
    parameter int TIMEOUT_CYC     = 1024
) (
    input logic           sd_clk,
    input logic           rst_L,
    dat_rx_phys_if.slave  bus
);
    localparam int NPW  = FIFO_WIDTH / 4;
    localparam int WC_W = (NPW > 1) ? $clog2(NPW) : 1;
    localparam int TC_W = $clog2(TIMEOUT_CYC + 1);
    localparam int NC_W = BLOCK_SZ_WIDTH + 1;

    localparam logic [WC_W-1:0] WC_LAST = WC_W'(NPW - 1);
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WAIT_START = 3'd1;
    localparam logic [2:0] RECV       = 3'd2;
    localparam logic [2:0] CRC        = 3'd3;
    localparam logic [2:0] END_BIT    = 3'd4;
    localparam logic [2:0] DONE       = 3'd5;

    logic [2:0]                 state;
    logic [BLOCK_SZ_WIDTH-1:0]  blk_sz_q;
    logic [BLOCK_CNT_WIDTH-1:0] blk_cnt_q;
    logic [TC_W-1:0]            tmo_cnt;
    logic [NC_W-1:0]            nib_cnt;
    logic [WC_W-1:0]            wcnt;
    logic [FIFO_WIDTH-1:0]      asm_q;
    logic [FIFO_WIDTH-1:0]      asm_nx;
    logic [FIFO_WIDTH-1:0]      wr_data;
    logic                       wr_pend;
    logic [3:0][15:0]           crc_q;
    logic [3:0][15:0]           crc_nx;
    logic [3:0][15:0]           crc_sh;
    logic [3:0]                 crc_msb;
    logic                       nib_last;
    logic                       crc_e, end_e, tmo_e, ovr_e;

    // Next assembly word, serial CRC16 step and CRC shift-out per line
    always_comb begin
        asm_nx   = FIFO_WIDTH'({asm_q, bus.DAT_din});
        crc_nx   = '0;
        crc_sh   = '0;
        crc_msb  = '0;
        for (int l = 0; l < 4; l++) begin
            crc_nx[l]  = {crc_q[l][14:0], 1'b0}
                       ^ ({16{crc_q[l][15] ^ bus.DAT_din[l]}}
                          & 16'h1021);
            crc_sh[l]  = {crc_q[l][14:0], 1'b0};
            crc_msb[l] = crc_q[l][15];
        end
        nib_last = (nib_cnt == ({blk_sz_q, 1'b0} - NC_W'(1)));
    end

    // Transfer FSM, counters, datapath and sticky error flags
    always_ff @(posedge sd_clk or negedge rst_L) begin
        if (!rst_L) begin
            state     <= IDLE;
            blk_sz_q  <= '0;
            blk_cnt_q <= '0;
            tmo_cnt   <= '0;
            nib_cnt   <= '0;
            wcnt      <= '0;
            asm_q     <= '0;
            wr_data   <= '0;
            wr_pend   <= 1'b0;
            crc_q     <= '0;
            crc_e     <= 1'b0;
            end_e     <= 1'b0;
            tmo_e     <= 1'b0;
            ovr_e     <= 1'b0;
        end else begin
            wr_pend <= 1'b0;
            if (wr_pend && bus.rx_buf_full)
                ovr_e <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (bus.read_flag && bus.block_cnt != '0) begin
                        blk_sz_q  <= bus.block_sz;
                        blk_cnt_q <= bus.block_cnt;
                        crc_e     <= 1'b0;
                        end_e     <= 1'b0;
                        tmo_e     <= 1'b0;
                        ovr_e     <= 1'b0;
                        tmo_cnt   <= '0;
                        state     <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    if (bus.DAT_din == 4'b0000) begin
                        crc_q   <= '0;
                        nib_cnt <= '0;
                        wcnt    <= '0;
                        state   <= RECV;
                    end else if (tmo_cnt == TC_LAST) begin
                        tmo_e <= 1'b1;
                        state <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TC_W'(1);
                    end
                end
                RECV: begin
                    asm_q   <= asm_nx;
                    crc_q   <= crc_nx;
                    nib_cnt <= nib_cnt + NC_W'(1);
                    if (wcnt == WC_LAST) begin
                        wcnt    <= '0;
                        wr_pend <= 1'b1;
                        wr_data <= asm_nx;
                    end else begin
                        wcnt <= wcnt + WC_W'(1);
                    end
                    if (nib_last) begin
                        nib_cnt <= '0;
                        state   <= CRC;
                    end
                end
                CRC: begin
                    if (bus.DAT_din != crc_msb)
                        crc_e <= 1'b1;
                    crc_q   <= crc_sh;
                    nib_cnt <= nib_cnt + NC_W'(1);
                    if (nib_cnt == NC_W'(15))
                        state <= END_BIT;
                end
                END_BIT: begin
                    if (bus.DAT_din != 4'b1111)
                        end_e <= 1'b1;
                    blk_cnt_q <= blk_cnt_q - BLOCK_CNT_WIDTH'(1);
                    if (blk_cnt_q == BLOCK_CNT_WIDTH'(1)) begin
                        state <= DONE;
                    end else begin
                        tmo_cnt <= '0;
                        state   <= WAIT_START;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rx_buf_wr_enb  = wr_pend & ~bus.rx_buf_full;
    assign bus.rx_buf_din_out = wr_data;
    assign bus.rx_busy        = (state != IDLE);
    assign bus.tf_finished    = (state == DONE);
    assign bus.crc_err        = crc_e;
    assign bus.end_bit_err    = end_e;
    assign bus.timeout_err    = tmo_e;
    assign bus.overrun_err    = ovr_e;
endmodule

// File: tb/tb_dat_rx_phys.sv
// Directed bench for dat_rx_phys: vector table of single-block
// transfers plus multi-block, timeout, reset and no-op sequences.
module tb_dat_rx_phys;
    localparam int TMO = 32;

    logic sd_clk;
    logic rst_L;

    dat_rx_phys_if #(
        .FIFO_WIDTH(32), .BLOCK_SZ_WIDTH(12), .BLOCK_CNT_WIDTH(16)
    ) bus ();

    dat_rx_phys #(
        .FIFO_WIDTH(32), .BLOCK_SZ_WIDTH(12),
        .BLOCK_CNT_WIDTH(16), .TIMEOUT_CYC(TMO)
    ) dut (
        .sd_clk(sd_clk),
        .rst_L(rst_L),
        .bus(bus)
    );

    initial sd_clk = 1'b0;
    always #5 sd_clk = ~sd_clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] wr_q[$];
    int tf_cnt = 0;

    // Capture FIFO writes and finish pulses mid-cycle
    always @(negedge sd_clk) begin
        if (bus.rx_buf_wr_enb) wr_q.push_back(bus.rx_buf_din_out);
        if (bus.tf_finished) tf_cnt++;
    end

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic step(input logic [3:0] d, input logic f);
        bus.DAT_din     = d;
        bus.rx_buf_full = f;
        @(posedge sd_clk);
        #1;
    endtask

    function automatic logic [15:0] crc_aug(input logic [15:0] r,
                                            input logic b);
        logic top;
        top = r[15];
        r = {r[14:0], b};
        if (top) r = r ^ 16'h1021;
        return r;
    endfunction

    logic [31:0] blk_w [2];
    int          blk_n;
    int          flip_line;
    logic [3:0]  end_nib;
    int          full_word;

    task automatic send_block();
        logic [15:0] cr [4];
        logic [3:0]  nib;
        logic [3:0]  cb;
        for (int l = 0; l < 4; l++) cr[l] = 16'h0;
        step(4'h0, 1'b0);
        for (int k = 0; k < blk_n * 8; k++) begin
            nib = blk_w[k/8][31 - 4*(k%8) -: 4];
            for (int l = 0; l < 4; l++) cr[l] = crc_aug(cr[l], nib[l]);
            step(nib, (full_word >= 0) && (k == full_word*8 + 8));
        end
        for (int l = 0; l < 4; l++)
            for (int j = 0; j < 16; j++) cr[l] = crc_aug(cr[l], 1'b0);
        if (flip_line >= 0) cr[flip_line][7] = ~cr[flip_line][7];
        for (int i = 0; i < 16; i++) begin
            for (int l = 0; l < 4; l++) cb[l] = cr[l][15-i];
            step(cb, (full_word == blk_n - 1) && (i == 0));
        end
        step(end_nib, 1'b0);
    endtask

    typedef struct {
        string       name;
        logic [31:0] w0;
        logic [31:0] w1;
        int          nw;
        int          flip;
        logic [3:0]  endn;
        int          full;
        int          exp_nwr;
        logic [31:0] exp_wr0;
        logic [31:0] exp_wr1;
        logic        exp_crc;
        logic        exp_end;
        logic        exp_ovr;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int wb;
        int t0;
        logic [31:0] got;

        vecs[0] = '{"dead", 32'hDEADBEEF, 32'h0, 1, -1, 4'hF, -1,
                    1, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"crcflip", 32'hDEADBEEF, 32'h0, 1, 2, 4'hF, -1,
                    1, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{"ovr_w0", 32'h12345678, 32'h9ABCDEF0, 2, -1, 4'hF, 0,
                    1, 32'h9ABCDEF0, 32'h0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{"endbit", 32'hA5A50F0F, 32'h0, 1, -1, 4'hE, -1,
                    1, 32'hA5A50F0F, 32'h0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{"ovr_w1", 32'h0BADF00D, 32'hCAFEBABE, 2, -1, 4'hF, 1,
                    1, 32'h0BADF00D, 32'h0, 1'b0, 1'b0, 1'b1};

        rst_L           = 1'b0;
        bus.DAT_din     = 4'hF;
        bus.block_sz    = '0;
        bus.block_cnt   = '0;
        bus.read_flag   = 1'b0;
        bus.rx_buf_full = 1'b0;
        #1;
        chk("rst_busy", 64'(bus.rx_busy), 64'd0);
        chk("rst_wr", 64'(bus.rx_buf_wr_enb), 64'd0);
        chk("rst_din", 64'(bus.rx_buf_din_out), 64'd0);
        chk("rst_flags", 64'({bus.tf_finished, bus.crc_err,
            bus.end_bit_err, bus.timeout_err, bus.overrun_err}), 64'd0);
        @(posedge sd_clk);
        @(posedge sd_clk);
        #1;
        rst_L = 1'b1;
        step(4'hF, 1'b0);

        for (int v = 0; v < 5; v++) begin
            blk_w[0]  = vecs[v].w0;
            blk_w[1]  = vecs[v].w1;
            blk_n     = vecs[v].nw;
            flip_line = vecs[v].flip;
            end_nib   = vecs[v].endn;
            full_word = vecs[v].full;
            wb = wr_q.size();
            t0 = tf_cnt;
            bus.block_sz  = 12'(vecs[v].nw * 4);
            bus.block_cnt = 16'd1;
            bus.read_flag = 1'b1;
            step(4'hF, 1'b0);
            bus.read_flag = 1'b0;
            chk({vecs[v].name, "_busy"}, 64'(bus.rx_busy), 64'd1);
            step(4'hF, 1'b0);
            step(4'hF, 1'b0);
            send_block();
            chk({vecs[v].name, "_tf"}, 64'(bus.tf_finished), 64'd1);
            step(4'hF, 1'b0);
            chk({vecs[v].name, "_idle"},
                64'({bus.rx_busy, bus.tf_finished}), 64'd0);
            chk({vecs[v].name, "_tfcnt"}, 64'(tf_cnt - t0), 64'd1);
            chk({vecs[v].name, "_nwr"}, 64'(wr_q.size() - wb),
                64'(vecs[v].exp_nwr));
            for (int i = 0; i < vecs[v].exp_nwr; i++) begin
                got = (wb + i < wr_q.size()) ? wr_q[wb+i] : 32'hx;
                chk({vecs[v].name, "_data"}, 64'(got),
                    64'((i == 0) ? vecs[v].exp_wr0 : vecs[v].exp_wr1));
            end
            chk({vecs[v].name, "_flags"},
                64'({bus.crc_err, bus.end_bit_err,
                     bus.timeout_err, bus.overrun_err}),
                64'({vecs[v].exp_crc, vecs[v].exp_end,
                     1'b0, vecs[v].exp_ovr}));
        end

        // two blocks of two words, inputs changed while busy
        wb = wr_q.size();
        t0 = tf_cnt;
        bus.block_sz  = 12'd8;
        bus.block_cnt = 16'd2;
        bus.read_flag = 1'b1;
        step(4'hF, 1'b0);
        bus.block_sz  = 12'd4;
        bus.block_cnt = 16'd9;
        flip_line = -1;
        end_nib   = 4'hF;
        full_word = -1;
        blk_n     = 2;
        blk_w[0]  = 32'h01234567;
        blk_w[1]  = 32'h89ABCDEF;
        send_block();
        chk("mb_mid_tf", 64'(bus.tf_finished), 64'd0);
        chk("mb_mid_busy", 64'(bus.rx_busy), 64'd1);
        for (int i = 0; i < 5; i++) step(4'hF, 1'b0);
        blk_w[0] = 32'hFEDCBA98;
        blk_w[1] = 32'h76543210;
        send_block();
        chk("mb_tf", 64'(bus.tf_finished), 64'd1);
        bus.read_flag = 1'b0;
        step(4'hF, 1'b0);
        chk("mb_tfcnt", 64'(tf_cnt - t0), 64'd1);
        chk("mb_nwr", 64'(wr_q.size() - wb), 64'd4);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] e;
            case (i)
                0: e = 32'h01234567;
                1: e = 32'h89ABCDEF;
                2: e = 32'hFEDCBA98;
                default: e = 32'h76543210;
            endcase
            got = (wb + i < wr_q.size()) ? wr_q[wb+i] : 32'hx;
            chk("mb_data", 64'(got), 64'(e));
        end
        chk("mb_flags", 64'({bus.crc_err, bus.end_bit_err,
            bus.timeout_err, bus.overrun_err}), 64'd0);

        // start-bit timeout
        wb = wr_q.size();
        t0 = tf_cnt;
        bus.block_sz  = 12'd4;
        bus.block_cnt = 16'd1;
        bus.read_flag = 1'b1;
        step(4'hF, 1'b0);
        bus.read_flag = 1'b0;
        for (int i = 0; i < TMO - 1; i++) step(4'hF, 1'b0);
        chk("tmo_early", 64'({bus.timeout_err, bus.rx_busy}), 64'b01);
        step(4'hF, 1'b0);
        chk("tmo_set", 64'({bus.timeout_err, bus.tf_finished}), 64'b11);
        step(4'hF, 1'b0);
        chk("tmo_idle", 64'(bus.rx_busy), 64'd0);
        chk("tmo_tfcnt", 64'(tf_cnt - t0), 64'd1);
        chk("tmo_nwr", 64'(wr_q.size() - wb), 64'd0);

        // block_cnt of zero does nothing
        t0 = tf_cnt;
        bus.block_cnt = 16'd0;
        bus.read_flag = 1'b1;
        step(4'hF, 1'b0);
        step(4'hF, 1'b0);
        bus.read_flag = 1'b0;
        chk("cnt0_busy", 64'(bus.rx_busy), 64'd0);
        chk("cnt0_tf", 64'(tf_cnt - t0), 64'd0);

        // reset after the third data nibble
        wb = wr_q.size();
        t0 = tf_cnt;
        bus.block_sz  = 12'd4;
        bus.block_cnt = 16'd1;
        bus.read_flag = 1'b1;
        step(4'hF, 1'b0);
        bus.read_flag = 1'b0;
        step(4'h0, 1'b0);
        step(4'hD, 1'b0);
        step(4'hE, 1'b0);
        step(4'hA, 1'b0);
        chk("rr_busy_pre", 64'(bus.rx_busy), 64'd1);
        rst_L = 1'b0;
        #1;
        chk("rr_outs", 64'({bus.rx_busy, bus.rx_buf_wr_enb,
            bus.tf_finished, bus.crc_err, bus.end_bit_err,
            bus.timeout_err, bus.overrun_err}), 64'd0);
        chk("rr_din", 64'(bus.rx_buf_din_out), 64'd0);
        step(4'hD, 1'b0);
        step(4'hB, 1'b0);
        rst_L = 1'b1;
        for (int i = 0; i < 10; i++) step(4'hE, 1'b0);
        chk("rr_idle", 64'(bus.rx_busy), 64'd0);
        chk("rr_nwr", 64'(wr_q.size() - wb), 64'd0);
        chk("rr_tf", 64'(tf_cnt - t0), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/dat_rx_phys.md
DAT_RX_PHYS -- requirements
Module: dat_rx_phys

Interface
REQ-001 The block SHALL use these parameters (name, default, meaning):
- FIFO_WIDTH, 32, Rx FIFO word width in bits; SHALL be a multiple of 4.
- BLOCK_SZ_WIDTH, 12, width of the block size field (bytes).
- BLOCK_CNT_WIDTH, 16, width of the block count field.
- TIMEOUT_CYC, 1024, maximum sd_clk cycles to wait for a start bit.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- sd_clk, in, 1, the only clock; all logic is on the rising edge.
- rst_L, in, 1, asynchronous active-low reset.
- DAT_din, in, 4, card DAT[3:0] lines, sampled on rising sd_clk.
- block_sz, in, BLOCK_SZ_WIDTH, bytes per block; a nonzero multiple of FIFO_WIDTH/8.
- block_cnt, in, BLOCK_CNT_WIDTH, number of blocks to receive.
- read_flag, in, 1, level request to start a read transfer.
- rx_buf_full, in, 1, Rx FIFO full flag.
- rx_buf_wr_enb, out, 1, one-cycle FIFO write strobe.
- rx_buf_din_out, out, FIFO_WIDTH, FIFO write data; valid only while rx_buf_wr_enb=1.
- rx_busy, out, 1, high whenever the state is not IDLE.
- tf_finished, out, 1, one-cycle pulse when all blocks are received.
- crc_err, out, 1, sticky CRC mismatch flag.
- end_bit_err, out, 1, sticky bad end bit flag.
- timeout_err, out, 1, sticky start-bit timeout flag.
- overrun_err, out, 1, sticky flag for a word dropped because the FIFO was full.

Function
REQ-003 The block SHALL implement the states IDLE, WAIT_START, RECV, CRC, END_BIT and DONE as a registered FSM.

REQ-004 In IDLE, when read_flag=1 and block_cnt!=0, the block SHALL:
- latch block_sz and block_cnt;
- clear all four sticky error flags;
- move to WAIT_START.
With block_cnt=0 it SHALL stay in IDLE and assert no outputs.

REQ-005 In WAIT_START the block SHALL count cycles.
- DAT_din=4'b0000 (start bit on all lines) SHALL move the FSM to RECV, with the next cycle carrying the first data nibble.
- Reaching TIMEOUT_CYC cycles SHALL set timeout_err and move to DONE.

REQ-006 In RECV the block SHALL shift one nibble per cycle into a FIFO_WIDTH assembly register, first nibble into the MSBs (bits FIFO_WIDTH-1 down to FIFO_WIDTH-4).

REQ-007 One cycle after the (FIFO_WIDTH/4)-th nibble of a word is sampled, the block SHALL pulse rx_buf_wr_enb for one cycle with the assembled word on rx_buf_din_out, unless rx_buf_full=1.

REQ-008 If rx_buf_full=1 at that cycle, the block SHALL:
- drop the word (no rx_buf_wr_enb);
- set overrun_err;
- continue receiving, since the card cannot be stalled.

REQ-009 Each block SHALL contain block_sz*2 data nibbles; the nibble counter SHALL be BLOCK_SZ_WIDTH+1 bits wide so it does not overflow. After the last nibble the FSM SHALL enter CRC.

REQ-010 The block SHALL keep four independent CRC16 registers, one per DAT line.
- Polynomial: x^16+x^12+x^5+1.
- Initial value: 0, reset at each start bit.
- Updated with each data bit of that line.

REQ-011 In CRC the block SHALL receive 16 bits per line, MSB first, over 16 cycles. A mismatch on any line SHALL set crc_err.

REQ-012 In END_BIT, the block SHALL check one cycle of DAT_din; any value other than 4'b1111 SHALL set end_bit_err.
- The block count SHALL then decrement.
- If blocks remain, the FSM SHALL return to WAIT_START with the timeout counter reset.
- Otherwise the FSM SHALL move to DONE.

REQ-013 Errors SHALL NOT abort a transfer, except timeout_err, which ends it (REQ-005).

REQ-014 DONE SHALL pulse tf_finished for one cycle and return to IDLE on the next cycle. A new transfer SHALL require read_flag to be sampled again in IDLE.

REQ-015 Changes on block_sz, block_cnt and read_flag while rx_busy=1 SHALL be ignored.

Reset
REQ-016 On rst_L=0 the block SHALL, asynchronously:
- enter IDLE;
- drive every output to 0 (rx_buf_din_out=0);
- clear all counters, CRC registers and the assembly register.

REQ-017 A reset mid-transfer SHALL discard any partial word, with no FIFO write. After rst_L rises, the block SHALL wait in IDLE for read_flag.

Verification
REQ-018 Single block, block_sz=4, block_cnt=1: start bit, then nibbles D,E,A,D,B,E,E,F, correct CRCs, end 4'b1111 -> one rx_buf_wr_enb with 0xDEADBEEF one cycle after the 8th nibble, then tf_finished pulse, all error flags 0.

REQ-019 block_sz=8, block_cnt=2, with 5 idle cycles (DAT_din=4'b1111) between blocks -> exactly 4 FIFO writes in order, a single tf_finished after the second end bit.

REQ-020 Block as in REQ-018 with one bit of the DAT[2] CRC flipped -> crc_err=1, word still written, tf_finished asserted.

REQ-021 read_flag=1 with DAT_din held at 4'b1111 -> timeout_err=1 exactly TIMEOUT_CYC cycles after entering WAIT_START, tf_finished pulse, no FIFO writes.

REQ-022 rx_buf_full=1 during the first word's write cycle -> no write for that word, overrun_err=1, second word still written.

REQ-023 rst_L=0 after the 3rd data nibble -> all outputs 0 immediately, no FIFO write, FSM in IDLE after reset release.
